// File: rtl/macc_seq_ctrl.sv
// Job sequencer for one fixed-latency MACC slice: streams operand pairs, marks the first term,
// tracks pipeline latency and holds the final sum under a valid/ready handshake.
// Optional build macro: MACC_SEQ_RELU_EN clamps negative results (including the bias-only path) to zero.
//
// Handshakes: a transfer occurs on the rising edge where both valid and ready are high; ready is a
// registered output that never depends combinationally on valid, and res_data is stable while res_valid=1.
module macc_seq_ctrl #(
    parameter int SIZEIN   = 16,
    parameter int SIZEOUT  = 40,
    parameter int CNT_W    = 16,
    parameter int MACC_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [CNT_W-1:0]          num_terms,
    input  logic signed [SIZEIN-1:0]  bias,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic signed [SIZEIN-1:0]  op_a,
    input  logic signed [SIZEIN-1:0]  op_b,
    output logic signed [SIZEIN-1:0]  macc_a,
    output logic signed [SIZEIN-1:0]  macc_b,
    output logic signed [SIZEIN-1:0]  macc_bias,
    output logic                      macc_accum_rst,
    input  logic signed [SIZEOUT-1:0] macc_accum_out,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic signed [SIZEOUT-1:0] res_data,
    output logic                      busy,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_start_ready;
    logic                      r_op_ready;
    logic                      r_res_valid;
    logic                      r_busy;
    logic signed [SIZEOUT-1:0] r_res_data;
    logic signed [SIZEIN-1:0]  r_macc_a;
    logic signed [SIZEIN-1:0]  r_macc_b;
    logic signed [SIZEIN-1:0]  r_macc_bias;
    logic                      r_macc_rst;
    logic                      r_first;
    logic [CNT_W-1:0]          r_remaining;
    logic [MACC_LAT:0]         r_last_pipe;

    logic                      w_start_fire;
    logic                      w_op_fire;
    logic                      w_last_fire;
    logic                      w_res_fire;
    logic [SIZEOUT-1:0]        w_bias_ext;

    assign w_start_fire = r_start_ready & start_valid;
    assign w_op_fire    = r_op_ready & op_valid;
    assign w_last_fire  = w_op_fire & (r_remaining == CNT_W'(1));
    assign w_res_fire   = r_res_valid & res_ready;
    assign w_bias_ext   = {{(SIZEOUT-SIZEIN){bias[SIZEIN-1]}}, bias};

    function automatic logic [SIZEOUT-1:0] shape_result(input logic [SIZEOUT-1:0] x);
`ifdef MACC_SEQ_RELU_EN
        return x[SIZEOUT-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_start_ready <= 1'b1;
            r_op_ready    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_res_data    <= '0;
            r_macc_a      <= '0;
            r_macc_b      <= '0;
            r_macc_bias   <= '0;
            r_macc_rst    <= 1'b0;
            r_first       <= 1'b0;
            r_remaining   <= '0;
            r_last_pipe   <= '0;
        end else begin
            // Stage 0 lines up with the operands on macc_a/macc_b; the top stage lines up with their sum.
            r_last_pipe <= {r_last_pipe[MACC_LAT-1:0], w_last_fire};
            r_macc_a    <= '0;
            r_macc_b    <= '0;
            r_macc_rst  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_fire) begin
                        r_macc_bias   <= bias;
                        r_remaining   <= num_terms;
                        r_first       <= 1'b1;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        if (num_terms == '0) begin
                            r_res_data  <= shape_result(w_bias_ext);
                            r_res_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_op_ready <= 1'b1;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_op_fire) begin
                        r_macc_a    <= op_a;
                        r_macc_b    <= op_b;
                        r_macc_rst  <= r_first;
                        r_first     <= 1'b0;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_last_fire) begin
                            r_op_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_last_pipe[MACC_LAT]) begin
                        r_res_data  <= shape_result(macc_accum_out);
                        r_res_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (w_res_fire) begin
                        r_res_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready    = r_start_ready;
    assign op_ready       = r_op_ready;
    assign res_valid      = r_res_valid;
    assign busy           = r_busy;
    assign res_data       = r_res_data;
    assign macc_a         = r_macc_a;
    assign macc_b         = r_macc_b;
    assign macc_bias      = r_macc_bias;
    assign macc_accum_rst = r_macc_rst;
    assign o_dbg_state    = r_state;

endmodule
